// File: rtl/cdm_pkg.sv
// Shared constants for the carry-disregard approximate multiplier family.
package cdm_pkg;

    localparam int OPW         = 8;
    localparam int PW          = 16;
    localparam int APPROX_COLS = 8;

    // Selects the product columns that are summed exactly.
    localparam logic [PW-1:0] HI_MASK = {{(PW-APPROX_COLS){1'b1}}, {APPROX_COLS{1'b0}}};

endpackage

// File: rtl/cdm8_a8_core.sv
// Combinational core: OR-reduced lower columns, exactly summed upper columns.
module cdm8_a8_core
    import cdm_pkg::*;
(
    input  logic [OPW-1:0] a_i,
    input  logic [OPW-1:0] b_i,
    output logic [PW-1:0]  r_o
);

    logic [PW-1:0]          row;
    logic [APPROX_COLS-1:0] lo_or;
    logic [PW-1:0]          hi_sum;

    // Each row is one shifted partial-product word.
    // OR-ing the low bits of all rows gives the per-column OR.
    // Summing the masked high bits gives the exact upper region.
    always_comb begin
        row    = '0;
        lo_or  = '0;
        hi_sum = '0;
        for (int i = 0; i < OPW; i++) begin
            row    = PW'(b_i & {OPW{a_i[i]}}) << i;
            lo_or  = lo_or | row[APPROX_COLS-1:0];
            hi_sum = hi_sum + (row & HI_MASK);
        end
    end

    // The upper-region sum never exceeds 63232, so no carry out of bit 15 exists.
    assign r_o = {hi_sum[PW-1:APPROX_COLS], lo_or};

endmodule

// File: rtl/cdm8_a8.sv
// 8x8 unsigned carry-disregard approximate multiplier, variant a8, registered output.
module cdm8_a8
    import cdm_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] A,
    input  logic [OPW-1:0] B,
    output logic [PW-1:0]  R
);

    logic [PW-1:0] r_d;
    logic [PW-1:0] r_q;

    cdm8_a8_core u_core (
        .a_i (A),
        .b_i (B),
        .r_o (r_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign R = r_q;

endmodule

// File: tb/tb_cdm8_a8.sv
// Self-checking bench for cdm8_a8 against a bit-level model of the column rules.
module tb_cdm8_a8;

    logic        clk;
    logic        rst_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] R;

    int n_checks;
    int n_fail;

    cdm8_a8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .R     (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Reference: walk every partial-product bit and place it by column weight.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [15:0] r, output int h);
        logic [7:0] lo;
        lo = '0;
        h  = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (a[i] && b[j]) begin
                    if (i + j < 8) lo[i+j] = 1'b1;
                    else           h = h + (1 << (i + j - 8));
                end
            end
        end
        r = {h[7:0], lo};
    endfunction

    task automatic apply_and_check(input logic [7:0] a, input logic [7:0] b,
                                   input logic [15:0] exp, input string name);
        A = a;
        B = b;
        @(posedge clk);
        #1;
        n_checks++;
        if (R !== exp) begin
            n_fail++;
            $display("FAIL %s: A=%0d B=%0d R=%0d expected %0d", name, a, b, R, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        A = 8'd255;
        B = 8'd255;
        #1;
        n_checks++;
        if (R !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_value: R=%h expected 0000", R);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (R !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_hold: R=%h expected 0000", R);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (R !== 16'd63487) begin
            n_fail++;
            $display("FAIL reset_release_first: R=%0d expected 63487", R);
        end
    endtask

    task automatic test_directed();
        apply_and_check(8'd16,  8'd16,  16'd256, "pow2_16x16");
        apply_and_check(8'd1,   8'd200, 16'd200, "one_x_200");
        apply_and_check(8'd255, 8'd1,   16'd255, "255_x_one");
        apply_and_check(8'd0,   8'd173, 16'd0,   "zero_x_173");
        apply_and_check(8'd3,   8'd3,   16'd7,   "carry_3x3");
        apply_and_check(8'd15,  8'd15,  16'd127, "carry_15x15");
        apply_and_check(8'd255, 8'd255, 16'hF7FF, "max_x_max");
    endtask

    task automatic test_back_to_back();
        apply_and_check(8'd3,   8'd3,   16'd7,     "b2b_3x3");
        apply_and_check(8'd16,  8'd16,  16'd256,   "b2b_16x16");
        apply_and_check(8'd255, 8'd255, 16'd63487, "b2b_255x255");
    endtask

    task automatic test_mid_reset();
        apply_and_check(8'd15, 8'd15, 16'd127, "pre_reset");
        A = 8'd200;
        B = 8'd77;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (R !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset_async: R=%h expected 0000", R);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (R !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset_hold: R=%h expected 0000", R);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply_and_check(8'd1, 8'd200, 16'd200, "post_reset_resume");
    endtask

    task automatic test_random();
        logic [15:0] exp;
        logic [7:0]  a;
        logic [7:0]  b;
        int          h;
        for (int k = 0; k < 300; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            model(a, b, exp, h);
            apply_and_check(a, b, exp, "random");
        end
    endtask

    task automatic test_exhaustive();
        logic [15:0] exp;
        int          h;
        int          prints;
        prints = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                model(8'(a), 8'(b), exp, h);
                A = 8'(a);
                B = 8'(b);
                @(posedge clk);
                #1;
                n_checks++;
                if (R !== exp) begin
                    n_fail++;
                    if (prints < 20) $display("FAIL sweep_value: A=%0d B=%0d R=%0d expected %0d", a, b, R, exp);
                    prints++;
                end
                n_checks++;
                if (!(int'(R) <= a * b)) begin
                    n_fail++;
                    if (prints < 20) $display("FAIL sweep_bound: A=%0d B=%0d R=%0d exceeds exact %0d", a, b, R, a * b);
                    prints++;
                end
                n_checks++;
                if (int'(R[15:8]) != h) begin
                    n_fail++;
                    if (prints < 20) $display("FAIL sweep_upper: A=%0d B=%0d R[15:8]=%0d expected %0d", a, b, R[15:8], h);
                    prints++;
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        A        = '0;
        B        = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_random();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdm8_a8.md
# cdm8_a8

Clocked 8x8 unsigned carry-disregard approximate multiplier, variant "a8". The lower 8 product columns are approximated by OR-ing their partial-product bits, with no carries generated. The upper columns are summed exactly. It sits in the approximate-arithmetic datapath as a drop-in, reduced-carry-chain replacement for an exact 8x8 multiplier. The output is registered.

## Interface
- Parameters: none. Operand width (8) and approximate column count (8) are fixed constants.
- clk — input, 1 — single clock; rising-edge active.
- rst_n — input, 1 — reset; asynchronous, active-low.
- A — input, 8 — unsigned multiplicand.
- B — input, 8 — unsigned multiplier.
- R — output, 16 — registered approximate product.

## Operation
- Partial products: pp[i][j] = A[i] & B[j], for i, j in 0..7. Each bit has column weight c = i + j, where c is in 0..14.
- Approximate region, columns 0..7:
  - R[c] = OR of all pp[i][j] with i + j = c.
  - No carry is produced; nothing from this region propagates into column 8 or above.
- Exact region, columns 8..14:
  - H = sum over all i + j ≥ 8 of pp[i][j]·2^(i+j−8), computed at full precision.
  - R[15:8] = H[7:0].
  - H never exceeds 255: the upper-region sum is at most 65025 − 1793 = 63232, i.e. H ≤ 247. No overflow or saturation logic is required.
- The function is purely unsigned. There is no sign handling and no rounding.
- Error is always non-positive relative to the exact product A·B. The OR of k bits never exceeds their sum, so R ≤ A·B.
- R is exact whenever no two partial-product bits share a column below 8. Examples:
  - either operand is 0;
  - either operand is a power of two;
  - a product whose only set bits lie in column 8 or above.

## Timing
- Latency is 1 cycle. R at rising edge n+1 reflects A and B sampled at rising edge n.
- The combinational path A/B → R register: one AND array, a per-column OR tree (columns 0..7), and a column-8..14 compressor plus final adder.
- rst_n low drives R to 16'h0000 immediately, independent of clk. R holds 0 while rst_n is low.
- On rst_n deassertion, the first rising edge loads f(A, B).
- Reset asserted mid-stream discards the in-flight product. No partial result is retained.
- There is no enable or handshake; the block accepts new operands every cycle.
- Back-to-back changes of A/B produce a new R each cycle with no bubbles.

## Structure
- Shared package cdm_pkg holds:
  - OPW = 8 (operand width);
  - PW = 16 (product width);
  - APPROX_COLS = 8 (boundary column between approximate and exact regions).
- One sub-module, cdm8_a8_core:
  - purely combinational;
  - computes the partial-product AND array, the lower-column OR reduction and the upper exact accumulation;
  - produces the 16-bit value.
- The top level cdm8_a8 instantiates cdm8_a8_core and the 16-bit async-reset output register.
- The exact region may use any exact compressor topology (Wallace, Dadda, or ripple) as long as the result is bit-exact to the H definition.

## Test plan
- Reset and extremes:
  - Assert rst_n = 0 with A = 255, B = 255 → R = 0 immediately.
  - Release reset, then one edge → R = 63487 (16'hF7FF; exact product 65025).
- Power-of-two and single-row operands, each one cycle after apply:
  - A = 16, B = 16 → R = 256.
  - A = 1, B = 200 → R = 200.
  - A = 255, B = 1 → R = 255.
  - A = 0, B = 173 → R = 0.
- Carry-disregard behaviour:
  - A = 3, B = 3 → R = 7 (exact 9).
  - A = 15, B = 15 → R = 127 (exact 225).
- Pipeline:
  - Apply (3,3), (16,16), (255,255) on consecutive edges → R sequence 7, 256, 63487, each lagging its inputs by one cycle.
  - Assert rst_n mid-sequence → R = 0 asynchronously; the next product resumes after release.
- Exhaustive sweep:
  - All 65536 (A, B) pairs against a behavioural model of the Operation rules → zero mismatches.
  - R ≤ A·B for every pair.
  - R[15:8] = H for every pair.
